// File: rtl/opti_pkg.sv
// Shared constants, types and the Q2.22 -> Q1.15 round/saturate helper
// used by the opti output conditioning stage.
package opti_pkg;

    localparam int DATA_W      = 24;
    localparam int FRAC_IN     = 22;
    localparam int OUT_W       = 16;
    localparam int FRAC_OUT    = 15;
    localparam int ROUND_SHIFT = FRAC_IN - FRAC_OUT;

    localparam logic [OUT_W-1:0] OUT_MAX = 16'h7FFF;
    localparam logic [OUT_W-1:0] OUT_MIN = 16'h8000;

    // One guard bit on top of the input so the rounding bias cannot overflow
    localparam int EXT_W    = DATA_W + 1;
    localparam int SCALED_W = EXT_W - ROUND_SHIFT;

    // Half an output LSB expressed in input LSBs
    localparam logic signed [EXT_W-1:0] ROUND_BIAS = EXT_W'(1) <<< (ROUND_SHIFT - 1);

    // Output range limits sign-extended to the Q3.15 intermediate width
    localparam logic signed [SCALED_W-1:0] SCALED_MAX = {{(SCALED_W-OUT_W){1'b0}}, OUT_MAX};
    localparam logic signed [SCALED_W-1:0] SCALED_MIN = {{(SCALED_W-OUT_W){1'b1}}, OUT_MIN};

    // Result of one conversion: the clamped sample and whether clamping happened
    typedef struct packed {
        logic [OUT_W-1:0] value;
        logic             sat;
    } conv_t;

    // Contents of the registered conversion stage in front of the FIFO
    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             sat;
        logic             valid;
    } stage_t;

    // Round half up, drop the extra fraction bits, then clamp to Q1.15
    function automatic conv_t round_sat(input logic [DATA_W-1:0] din);
        logic signed [EXT_W-1:0]    ext;
        logic signed [EXT_W-1:0]    biased;
        logic signed [EXT_W-1:0]    shifted;
        logic signed [SCALED_W-1:0] scaled;
        conv_t                      res;
        ext     = $signed({din[DATA_W-1], din});
        biased  = ext + ROUND_BIAS;
        shifted = biased >>> ROUND_SHIFT;
        scaled  = shifted[SCALED_W-1:0];
        if (scaled > SCALED_MAX) begin
            res.value = OUT_MAX;
            res.sat   = 1'b1;
        end else if (scaled < SCALED_MIN) begin
            res.value = OUT_MIN;
            res.sat   = 1'b1;
        end else begin
            res.value = scaled[OUT_W-1:0];
            res.sat   = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/opti_sync_fifo.sv
// Show-ahead synchronous FIFO: the head word is always visible on rd_data,
// occupancy is tracked by an explicit level counter so pointers can wrap freely.
module opti_sync_fifo
    import opti_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = OUT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    output logic          wr_accept,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          rd_valid,
    output logic [AW:0]   level
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          rd_fire;
    logic          wr_fire;

    // A full FIFO still takes a write when the head is being popped in the same cycle;
    // an empty FIFO can never pop, so a fresh write is not readable until the next cycle
    always_comb begin
        empty     = (level == '0);
        full      = (level == FULL_LEVEL);
        rd_fire   = rd_en && !empty;
        wr_fire   = wr_en && (!full || rd_fire);
        wr_accept = wr_fire;
        rd_valid  = !empty;
        rd_data   = empty ? '0 : mem[rd_ptr];
    end

    // Storage array carries no reset so it maps onto plain RAM/registers
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; a reset drops everything buffered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_fire, rd_fire})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/opti_out_stage.sv
// Output conditioning stage behind the IIR filter: rounds/saturates Q2.22 to
// Q1.15, buffers in a small FIFO and exposes a ready/valid stream with status.
module opti_out_stage
    import opti_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic [OUT_W-1:0]  m_data,
    output logic              m_valid,
    input  logic              m_ready,
    input  logic              clear,
    output logic              sat_flag,
    output logic              ovf_flag,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  sat_cnt,
    output logic [AW:0]       level
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    conv_t  conv;
    stage_t stage;
    logic   wr_accept;
    logic   drop_evt;
    logic   sat_evt;

    // Combinational rounding and clamping of the incoming sample
    always_comb begin
        conv = round_sat(data_in);
    end

    // Conversion register; valid follows valid_in every cycle since the filter cannot stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage.data  <= conv.value;
            stage.sat   <= conv.sat;
            stage.valid <= valid_in;
        end
    end

    opti_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (OUT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (stage.valid),
        .wr_data   (stage.data),
        .wr_accept (wr_accept),
        .rd_en     (m_ready),
        .rd_data   (m_data),
        .rd_valid  (m_valid),
        .level     (level)
    );

    // A staged sample the FIFO cannot take is lost; saturation counts whether or not it is kept
    always_comb begin
        drop_evt = stage.valid && !wr_accept;
        sat_evt  = stage.valid && stage.sat;
    end

    // Sticky flags and saturating event counters; clear takes priority over new events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
            drop_cnt <= '0;
            sat_cnt  <= '0;
        end else if (clear) begin
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
            drop_cnt <= '0;
            sat_cnt  <= '0;
        end else begin
            if (drop_evt) begin
                ovf_flag <= 1'b1;
                if (drop_cnt != CNT_MAX) begin
                    drop_cnt <= drop_cnt + CNT_W'(1);
                end
            end
            if (sat_evt) begin
                sat_flag <= 1'b1;
                if (sat_cnt != CNT_MAX) begin
                    sat_cnt <= sat_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_opti_out_stage.sv
// Bench for opti_out_stage: directed test-plan cases plus randomized traffic,
// all compared against a queue-based reference model.
module tb_opti_out_stage;

    localparam int DEPTH   = 8;
    localparam int AW      = 3;
    localparam int CNT_W   = 16;
    localparam int CNT_TOP = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [23:0]       data_in;
    logic              valid_in;
    logic [15:0]       m_data;
    logic              m_valid;
    logic              m_ready;
    logic              clear;
    logic              sat_flag;
    logic              ovf_flag;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  sat_cnt;
    logic [AW:0]       level;

    int assertCount = 0;
    int failCount   = 0;
    bit checkEn     = 1'b0;

    // reference model state
    logic [15:0] refQ[$];
    bit          refStgValid = 1'b0;
    logic [15:0] refStgData  = '0;
    bit          refStgSat   = 1'b0;
    bit          refSatFlag  = 1'b0;
    bit          refOvfFlag  = 1'b0;
    int          refDrop     = 0;
    int          refSatCnt   = 0;

    opti_out_stage #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .valid_in (valid_in),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .clear    (clear),
        .sat_flag (sat_flag),
        .ovf_flag (ovf_flag),
        .drop_cnt (drop_cnt),
        .sat_cnt  (sat_cnt),
        .level    (level)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] d, input logic v, input logic r, input logic c);
        data_in  = d;
        valid_in = v;
        m_ready  = r;
        clear    = c;
        @(posedge clk);
        #1;
    endtask

    // Real-valued reference: value in output LSBs, round half up, clamp to Q1.15
    function automatic logic [15:0] refConvert(input logic [23:0] d, output bit sat);
        int  v;
        int  r;
        real scaled;
        v      = int'($signed(d));
        scaled = $floor(real'(v) / 128.0 + 0.5);
        r      = int'(scaled);
        if (r > 32767) begin
            sat = 1'b1;
            return 16'h7FFF;
        end else if (r < -32768) begin
            sat = 1'b1;
            return 16'h8000;
        end
        sat = 1'b0;
        return r[15:0];
    endfunction

    task automatic modelReset();
        refQ.delete();
        refStgValid = 1'b0;
        refStgData  = '0;
        refStgSat   = 1'b0;
        refSatFlag  = 1'b0;
        refOvfFlag  = 1'b0;
        refDrop     = 0;
        refSatCnt   = 0;
    endtask

    task automatic modelStep();
        int sz;
        bit doRead;
        bit doWrite;
        bit dropEv;
        bit satEv;
        sz      = refQ.size();
        doRead  = (sz != 0) && m_ready;
        doWrite = refStgValid && ((sz < DEPTH) || doRead);
        dropEv  = refStgValid && !doWrite;
        satEv   = refStgValid && refStgSat;
        if (doRead)  void'(refQ.pop_front());
        if (doWrite) refQ.push_back(refStgData);
        if (clear) begin
            refSatFlag = 1'b0;
            refOvfFlag = 1'b0;
            refDrop    = 0;
            refSatCnt  = 0;
        end else begin
            if (dropEv) begin
                refOvfFlag = 1'b1;
                if (refDrop < CNT_TOP) refDrop++;
            end
            if (satEv) begin
                refSatFlag = 1'b1;
                if (refSatCnt < CNT_TOP) refSatCnt++;
            end
        end
        refStgValid = valid_in;
        refStgData  = refConvert(data_in, refStgSat);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) modelReset();
            else        modelStep();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (checkEn && rst_n) begin
                checkOutput("model_m_valid", {31'd0, m_valid}, {31'd0, refQ.size() != 0});
                checkOutput("model_m_data", {16'd0, m_data}, (refQ.size() != 0) ? {16'd0, refQ[0]} : 32'd0);
                checkOutput("model_level", {28'd0, level}, refQ.size());
                checkOutput("model_sat_flag", {31'd0, sat_flag}, {31'd0, refSatFlag});
                checkOutput("model_ovf_flag", {31'd0, ovf_flag}, {31'd0, refOvfFlag});
                checkOutput("model_drop_cnt", {16'd0, drop_cnt}, refDrop);
                checkOutput("model_sat_cnt", {16'd0, sat_cnt}, refSatCnt);
            end
        end
    end

    initial begin
        logic [23:0] roundIn  [6];
        logic [15:0] roundExp [6];
        roundIn[0] = 24'h200000; roundExp[0] = 16'h4000;
        roundIn[1] = 24'h000040; roundExp[1] = 16'h0001;
        roundIn[2] = 24'hFFFFC0; roundExp[2] = 16'h0000;
        roundIn[3] = 24'hC00000; roundExp[3] = 16'h8000;
        roundIn[4] = 24'h400000; roundExp[4] = 16'h7FFF;
        roundIn[5] = 24'hA00000; roundExp[5] = 16'h8000;

        rst_n    = 1'b0;
        data_in  = '0;
        valid_in = 1'b0;
        m_ready  = 1'b0;
        clear    = 1'b0;
        #12;
        checkOutput("reset_m_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("reset_m_data", {16'd0, m_data}, 32'd0);
        checkOutput("reset_level", {28'd0, level}, 32'd0);
        checkOutput("reset_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkEn = 1'b1;

        // rounding, scaling and saturation with a ready consumer
        for (int i = 0; i < 6; i++) begin
            applyStimulus(roundIn[i], 1'b1, 1'b1, 1'b0);
            checkOutput("latency_not_yet", {31'd0, m_valid}, 32'd0);
            applyStimulus(24'd0, 1'b0, 1'b1, 1'b0);
            checkOutput("conv_valid", {31'd0, m_valid}, 32'd1);
            checkOutput("conv_data", {16'd0, m_data}, {16'd0, roundExp[i]});
            applyStimulus(24'd0, 1'b0, 1'b1, 1'b0);
            if (i == 3) checkOutput("minus_one_no_sat", {31'd0, sat_flag}, 32'd0);
        end
        checkOutput("sat_flag_set", {31'd0, sat_flag}, 32'd1);
        checkOutput("sat_cnt_two", {16'd0, sat_cnt}, 32'd2);

        // backpressure: ten samples into an eight-deep FIFO
        for (int i = 1; i <= 10; i++) applyStimulus(24'(i * 128), 1'b1, 1'b0, 1'b0);
        applyStimulus(24'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_level", {28'd0, level}, 32'd8);
        checkOutput("ovf_flag", {31'd0, ovf_flag}, 32'd1);
        checkOutput("ovf_drop_cnt", {16'd0, drop_cnt}, 32'd2);
        for (int i = 1; i <= 8; i++) begin
            checkOutput("drain_data", {16'd0, m_data}, i);
            applyStimulus(24'd0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("drain_empty", {31'd0, m_valid}, 32'd0);

        // full FIFO with simultaneous read and write across pointer wrap
        for (int i = 0; i < 8; i++) applyStimulus(24'((100 + i) * 128), 1'b1, 1'b0, 1'b0);
        applyStimulus(24'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(24'(108 * 128), 1'b1, 1'b0, 1'b0);
        checkOutput("full_level", {28'd0, level}, 32'd8);
        for (int j = 0; j < 20; j++) begin
            applyStimulus(24'((109 + j) * 128), 1'b1, 1'b1, 1'b0);
            checkOutput("rw_level", {28'd0, level}, 32'd8);
            checkOutput("rw_order", {16'd0, m_data}, 101 + j);
            checkOutput("rw_no_drop", {16'd0, drop_cnt}, 32'd2);
        end
        for (int j = 0; j < 10; j++) applyStimulus(24'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("rw_drained", {28'd0, level}, 32'd0);

        // clear leaves buffered data alone
        for (int i = 0; i < 3; i++) applyStimulus(24'h7FFFFF, 1'b1, 1'b0, 1'b0);
        applyStimulus(24'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(24'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("clear_sat_flag", {31'd0, sat_flag}, 32'd0);
        checkOutput("clear_ovf_flag", {31'd0, ovf_flag}, 32'd0);
        checkOutput("clear_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        checkOutput("clear_sat_cnt", {16'd0, sat_cnt}, 32'd0);
        checkOutput("clear_level", {28'd0, level}, 32'd3);
        checkOutput("clear_data", {16'd0, m_data}, 32'h7FFF);
        for (int i = 0; i < 4; i++) applyStimulus(24'd0, 1'b0, 1'b1, 1'b0);

        // randomized traffic with varying backpressure and occasional clear
        for (int n = 0; n < 800; n++) begin
            logic [23:0] d;
            logic        v;
            logic        r;
            logic        c;
            d = 24'($urandom);
            if ($urandom_range(0, 1) == 0) d = 24'($signed(d[19:0]));
            v = ($urandom_range(0, 3) != 0);
            if (n < 400) r = ($urandom_range(0, 2) == 0);
            else         r = ($urandom_range(0, 4) != 0);
            c = ($urandom_range(0, 60) == 0);
            applyStimulus(d, v, r, c);
        end

        // asynchronous reset in the middle of traffic
        for (int i = 0; i < 5; i++) applyStimulus(24'h7FFFFF - 24'(i), 1'b1, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_m_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("async_rst_level", {28'd0, level}, 32'd0);
        checkOutput("async_rst_m_data", {16'd0, m_data}, 32'd0);
        checkOutput("async_rst_sat_flag", {31'd0, sat_flag}, 32'd0);
        valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(24'h200000, 1'b1, 1'b1, 1'b0);
        checkOutput("post_rst_not_yet", {31'd0, m_valid}, 32'd0);
        applyStimulus(24'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("post_rst_valid", {31'd0, m_valid}, 32'd1);
        checkOutput("post_rst_data", {16'd0, m_data}, 32'h4000);
        for (int n = 0; n < 200; n++) begin
            applyStimulus(24'($urandom), ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0), 1'b0);
        end
        applyStimulus(24'd0, 1'b0, 1'b1, 1'b0);

        checkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
